memoria_escritor: RTL and testbench
===================================

MEMORIA_ESCRITOR -- requirements
Module: memoria_escritor

Interface
REQ-001 The module SHALL have parameter ANCHO_DIR, default 7, meaning address width (depth = 2^ANCHO_DIR = 128 words).
REQ-002 The module SHALL have parameter ANCHO_DATO, default 13, meaning word width.
REQ-003 The module SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-004 The module SHALL have port reset  input  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
REQ-005 The module SHALL have port inicio  input  1  start pulse; begins a load session.
REQ-006 The module SHALL have port terminar  input  1  ends a load session early.
REQ-007 The module SHALL have port dato_in  input  ANCHO_DATO  word to write.
REQ-008 The module SHALL have port dato_valido  input  1  dato_in is valid.
REQ-009 The module SHALL have port dato_listo  output  1  module accepts a word this cycle.
REQ-010 The module SHALL have port direccion  input  ANCHO_DIR  read address.
REQ-011 The module SHALL have port valor  output  ANCHO_DATO  registered read data.
REQ-012 The module SHALL have port ocupado  output  1  load session active.
REQ-013 The module SHALL have port completo  output  1  load session finished.
REQ-014 The module SHALL have port cuenta  output  ANCHO_DIR+1  words written in current or last session (0..128).

Function
REQ-015 Storage SHALL be 2^ANCHO_DIR x ANCHO_DATO words, one write port and one read port.
REQ-016 FSM states SHALL be ESPERA, CARGA and LLENO; dato_listo = ocupado = (state == CARGA); completo = (state == LLENO).
REQ-017 ESPERA or LLENO with inicio=1 SHALL go to CARGA next cycle, clearing the write pointer, cuenta and completo.
REQ-018 inicio while in CARGA SHALL be ignored.
REQ-019 In CARGA, dato_valido=1 in the same cycle as dato_listo=1 SHALL write dato_in to mem[pointer] and increment pointer and cuenta by 1.
REQ-020 dato_valido=0 SHALL cause no write and no pointer change; dato_valido outside CARGA SHALL be ignored.
REQ-021 A write to address 2^ANCHO_DIR-1 SHALL move to LLENO next cycle with cuenta = 128; the pointer SHALL never wrap within a session.
REQ-022 terminar=1 in CARGA SHALL move to LLENO next cycle; a word accepted in that same cycle SHALL be written and counted.
REQ-023 terminar outside CARGA SHALL be ignored; inicio has priority over terminar.
REQ-024 Read: valor SHALL equal mem[direccion] as sampled at the previous rising edge (1-cycle latency), in every state.
REQ-025 Read and write to the same address in one cycle SHALL return the old word (read-before-write).
REQ-026 Memory contents SHALL persist across sessions; a new session overwrites only addresses it writes.

Reset
REQ-027 reset=0 at a rising edge SHALL set state ESPERA, pointer 0, cuenta 0, valor 0, dato_listo 0, ocupado 0, completo 0.
REQ-028 Reset SHALL NOT clear memory contents; words written before reset remain readable afterwards.
REQ-029 Reset asserted mid-CARGA SHALL abort the session with no write that cycle, even if dato_valido=1.
REQ-030 Reset SHALL take priority over inicio, terminar and dato_valido.

Verification
REQ-031 Reset, then inicio, then 128 words i+0x100 with dato_valido held 1 -> completo=1 one cycle after the last write, cuenta=128, dato_listo=0; reading direccion=7'b0010110 returns 13'h116 one cycle later.
REQ-032 inicio, 3 words with dato_valido toggling 1,0,1,0,1, then terminar -> cuenta=3, LLENO, addresses 0..2 hold the words, address 3 unchanged.
REQ-033 terminar asserted together with the accepted 5th word -> cuenta=5 and mem[4] written.
REQ-034 Reset in CARGA after 10 words with dato_valido=1 -> all outputs 0, cuenta=0, mem[10] not written, mem[0..9] still readable.
REQ-035 Read address 5 in the cycle 13'h1ABC is written there -> valor shows the old word, then 13'h1ABC on the following read.
REQ-036 inicio in LLENO -> CARGA, cuenta=0, completo=0; inicio pulsed again mid-CARGA -> no effect on pointer or cuenta.

Source files
------------

// File: rtl/memoria_escritor.sv
// memoria_escritor: session-based sequential loader into a word memory with a registered read port.
module memoria_escritor #(
    parameter int ANCHO_DIR  = 7,
    parameter int ANCHO_DATO = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  inicio,
    input  logic                  terminar,
    input  logic [ANCHO_DATO-1:0] dato_in,
    input  logic                  dato_valido,
    output logic                  dato_listo,
    input  logic [ANCHO_DIR-1:0]  direccion,
    output logic [ANCHO_DATO-1:0] valor,
    output logic                  ocupado,
    output logic                  completo,
    output logic [ANCHO_DIR:0]    cuenta
);
    typedef enum logic [1:0] {ESPERA, CARGA, LLENO} estado_t;
    estado_t estado, sig;
    logic [ANCHO_DATO-1:0] mem [0:2**ANCHO_DIR-1];
    logic escribe;
    assign escribe = dato_listo && dato_valido;
    always_ff @(posedge clk)
        estado <= !reset ? ESPERA : sig;
    always_comb begin
        sig = estado;
        if (estado != CARGA)
            sig = inicio ? CARGA : estado;
        else if (terminar || (escribe && &cuenta[ANCHO_DIR-1:0]))
            sig = LLENO;
    end
    always_comb begin
        dato_listo = estado == CARGA;
        ocupado    = estado == CARGA;
        completo   = estado == LLENO;
    end
    // The write pointer is the low bits of cuenta; the top bit only sets on the final word.
    always_ff @(posedge clk) begin
        if (!reset)
            cuenta <= '0;
        else if (estado != CARGA && inicio)
            cuenta <= '0;
        else if (escribe)
            cuenta <= cuenta + 1'b1;
    end
    always_ff @(posedge clk)
        if (reset && escribe)
            mem[cuenta[ANCHO_DIR-1:0]] <= dato_in;
    always_ff @(posedge clk)
        valor <= !reset ? '0 : mem[direccion];
endmodule

// File: tb/tb_memoria_escritor.sv
// tb_memoria_escritor: scoreboard bench with directed scenarios and random traffic against a session-level model.
module tb_memoria_escritor;
    logic        clk = 0;
    logic        reset, inicio, terminar, dato_valido;
    logic [12:0] dato_in;
    logic [6:0]  direccion;
    logic        dato_listo, ocupado, completo;
    logic [12:0] valor;
    logic [7:0]  cuenta;

    memoria_escritor dut (
        .clk(clk), .reset(reset), .inicio(inicio), .terminar(terminar),
        .dato_in(dato_in), .dato_valido(dato_valido), .dato_listo(dato_listo),
        .direccion(direccion), .valor(valor), .ocupado(ocupado),
        .completo(completo), .cuenta(cuenta)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] valor;
        bit          conocido;
        logic [7:0]  cuenta;
        bit          ocupado;
        bit          completo;
    } esperado_t;

    esperado_t sb[$];
    int n_chk = 0;
    int n_fail = 0;

    int ref_mem [128];
    bit ref_ok  [128];
    bit activa = 0;
    bit hecha  = 0;
    int num    = 0;

    task automatic chk(input string nombre, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nombre, got, want, $time);
        end
    endtask

    // One clock of stimulus: drive inputs, advance the model, queue what must be seen after the edge.
    task automatic tick(input bit rst_n, input bit ini, input bit ter, input bit dv,
                        input int din, input int dir);
        esperado_t e;
        reset = rst_n; inicio = ini; terminar = ter; dato_valido = dv;
        dato_in = 13'(din); direccion = 7'(dir);
        e.valor    = rst_n ? 13'(ref_mem[dir]) : 13'h0;
        e.conocido = !rst_n || ref_ok[dir];
        if (!rst_n) begin
            activa = 0; hecha = 0; num = 0;
        end else if (!activa) begin
            if (ini) begin
                activa = 1; hecha = 0; num = 0;
            end
        end else begin
            if (dv) begin
                ref_mem[num] = din & 'h1FFF;
                ref_ok[num]  = 1;
                num++;
            end
            if (num == 128 || ter) begin
                activa = 0; hecha = 1;
            end
        end
        e.cuenta = 8'(num);
        e.ocupado = activa;
        e.completo = hecha;
        sb.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        esperado_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.conocido) chk("valor", 32'(valor), 32'(e.valor));
                chk("cuenta", 32'(cuenta), 32'(e.cuenta));
                chk("ocupado", 32'(ocupado), 32'(e.ocupado));
                chk("dato_listo", 32'(dato_listo), 32'(e.ocupado));
                chk("completo", 32'(completo), 32'(e.completo));
            end
        end
    end

    initial begin
        for (int i = 0; i < 128; i++) begin ref_mem[i] = 0; ref_ok[i] = 0; end
        reset = 0; inicio = 0; terminar = 0; dato_valido = 0; dato_in = 0; direccion = 0;
        @(negedge clk);
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 1, 1, 1, 0, 0);
        // Full 128-word session, then read back address 0x16
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 128; i++) tick(1, 0, 0, 1, i + 'h100, 0);
        tick(1, 0, 0, 1, 'h1FFF, 'h16);
        tick(1, 0, 1, 0, 0, 'h16);
        tick(1, 0, 0, 0, 0, 127);
        // Gapped writes then early termination
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, (i % 2) == 0, 'h0A0 + i, 0);
        tick(1, 0, 1, 0, 0, 0);
        for (int a = 0; a < 5; a++) tick(1, 0, 0, 0, 0, a);
        // Termination together with an accepted fifth word
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(1, 0, 0, 1, 'h0B0 + i, 0);
        tick(1, 0, 1, 1, 'h0B4, 4);
        tick(1, 0, 0, 0, 0, 4);
        tick(1, 0, 0, 0, 0, 5);
        // Reset mid-session with a word offered
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(1, 0, 0, 1, 'h0C0 + i, 0);
        tick(0, 1, 1, 1, 'h1555, 10);
        for (int a = 0; a <= 10; a++) tick(1, 0, 0, 0, 0, a);
        // Read-before-write at address 5
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(1, 0, 0, 1, 'h0D0 + i, 5);
        tick(1, 0, 0, 1, 'h1ABC, 5);
        tick(1, 0, 0, 0, 0, 5);
        // inicio from LLENO restarts; inicio during CARGA is ignored
        tick(1, 0, 1, 0, 0, 0);
        tick(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(1, 0, 0, 1, 'h0E0 + i, 0);
        tick(1, 1, 0, 0, 0, 0);
        tick(1, 1, 0, 1, 'h0E3, 3);
        tick(1, 0, 0, 1, 'h0E4, 4);
        tick(1, 0, 1, 0, 0, 4);
        // Random traffic
        for (int i = 0; i < 3000; i++)
            tick($urandom_range(0, 199) != 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 8191), $urandom_range(0, 127));
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
